// File: rtl/ps2_rx_frame_funcmod.sv
// PS/2 device-to-host frame receiver: pin sync, clock deglitch, 11-bit frame check, E0/F0 prefix folding.
// Optional PS2_PARITY_CHECK_EN: when defined, odd-parity failures abort the frame as an error.
module ps2_rx_frame_funcmod #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       oTrig,
  output logic [7:0] oData,
  output logic       oExt,
  output logic       oBreak,
  output logic       oErr,
  output logic [2:0] oState
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [FCW-1:0] FC_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_MAX = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  logic           clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic           flt_lvl_q;
  logic [FCW-1:0] flt_cnt_q;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  state_t         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           ext_q, ext_d, brk_q, brk_d;
  logic           trig_q, trig_d, err_q, err_d;
  logic [7:0]     data_q, data_d;
  logic           oext_q, oext_d, obrk_q, obrk_d;

  logic flt_diff, flt_flip, fall, in_frame, to_hit, par_ok, par_good;

  assign flt_diff = clk_sync_q != flt_lvl_q;
  assign flt_flip = flt_diff && (flt_cnt_q == FC_MAX);
  assign fall     = flt_flip && flt_lvl_q;
  assign in_frame = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
  assign to_hit   = in_frame && (to_cnt_q == TO_MAX);
  assign par_ok   = ^{shift_q, par_q};

`ifdef PS2_PARITY_CHECK_EN
  assign par_good = par_ok;
`else
  // Parity is still captured and evaluated, but never gates frame acceptance.
  assign par_good = par_ok | 1'b1;
`endif

  always_comb begin
    to_cnt_d = (!in_frame || flt_flip) ? '0 : to_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    trig_d  = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    oext_d  = oext_q;
    obrk_d  = obrk_q;
    case (state_q)
      S_IDLE: if (fall && !dat_sync_q) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
      end
      S_DATA: if (fall) begin
        shift_d[bit_q] = dat_sync_q;
        bit_d          = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        par_d   = dat_sync_q;
        state_d = S_STOP;
      end
      S_STOP: if (fall) begin
        if (dat_sync_q && par_good) begin
          state_d = S_DONE;
          if (shift_q == 8'hE0)      ext_d = 1'b1;
          else if (shift_q == 8'hF0) brk_d = 1'b1;
          else begin
            trig_d = 1'b1;
            data_d = shift_q;
            oext_d = ext_q;
            obrk_d = brk_q;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A fall in the same cycle as expiry wins; only a silent line times out.
    if (to_hit && !fall) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      flt_lvl_q  <= 1'b1;
      flt_cnt_q  <= '0;
      to_cnt_q   <= '0;
      state_q    <= S_IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      trig_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      oext_q     <= 1'b0;
      obrk_q     <= 1'b0;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
      if (flt_flip) begin
        flt_lvl_q <= ~flt_lvl_q;
        flt_cnt_q <= '0;
      end else if (flt_diff) begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end else begin
        flt_cnt_q <= '0;
      end
      to_cnt_q <= to_cnt_d;
      state_q  <= state_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      trig_q   <= trig_d;
      err_q    <= err_d;
      data_q   <= data_d;
      oext_q   <= oext_d;
      obrk_q   <= obrk_d;
    end
  end

  assign oTrig  = trig_q;
  assign oErr   = err_q;
  assign oData  = data_q;
  assign oExt   = oext_q;
  assign oBreak = obrk_q;
  assign oState = state_q;

endmodule

// File: tb/tb_ps2_rx_frame_funcmod.sv
// Scoreboard bench for ps2_rx_frame_funcmod: bit-banged PS/2 frames in, expected events queued and matched on oTrig/oErr.
`timescale 1ns/1ps
module tb_ps2_rx_frame_funcmod;
  localparam int FL = 4;
  localparam int TO = 300;
  localparam int HP = 20;

  logic       CLOCK = 1'b0;
  logic       RST = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       oTrig, oExt, oBreak, oErr;
  logic [7:0] oData;
  logic [2:0] oState;

  ps2_rx_frame_funcmod #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .CLOCK(CLOCK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .oTrig(oTrig), .oData(oData), .oExt(oExt), .oBreak(oBreak),
    .oErr(oErr), .oState(oState)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] d, input logic e, input logic b);
    ev_t ev;
    ev = '{err: 1'b0, data: d, ext: e, brk: b};
    exp_q.push_back(ev);
  endtask

  task automatic exp_err();
    ev_t ev;
    ev = '{err: 1'b1, data: 8'h00, ext: 1'b0, brk: 1'b0};
    exp_q.push_back(ev);
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge CLOCK); #1 PS2_DAT = b;
    repeat (HP/2) @(posedge CLOCK);
    #1 PS2_CLK = 1'b0;
    repeat (HP) @(posedge CLOCK);
    #1 PS2_CLK = 1'b1;
    repeat (HP/2) @(posedge CLOCK);
  endtask

  task automatic send(input logic [7:0] d, input logic par_flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d ^ par_flip);
    ps2_bit(1'b1);
    repeat (HP) @(posedge CLOCK);
  endtask

  // Output monitor: every oTrig/oErr pulse must match the head of the expectation queue.
  always @(negedge CLOCK) begin
    if (!RST && (oTrig || oErr)) begin
      ev_t ev;
      chk("trig_err_excl", 32'(oTrig & oErr), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ev", 32'({oTrig, oErr}), 32'd0);
      end else begin
        ev = exp_q.pop_front();
        if (ev.err) begin
          chk("err_ev", 32'({oTrig, oErr}), 32'b01);
        end else begin
          chk("trig_ev", 32'({oTrig, oErr}), 32'b10);
          chk("data", 32'(oData), 32'(ev.data));
          chk("ext", 32'(oExt), 32'(ev.ext));
          chk("brk", 32'(oBreak), 32'(ev.brk));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RST = 1'b1;
    repeat (5) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_trig", 32'(oTrig), 32'd0);
    chk("rst_err", 32'(oErr), 32'd0);
    chk("rst_data", 32'(oData), 32'd0);
    @(posedge CLOCK); #1 RST = 1'b0;
    repeat (10) @(posedge CLOCK);

    // plain make code
    exp_byte(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);

    // break code, then a plain repeat clears break
    send(8'hF0, 1'b0);
    exp_byte(8'h1C, 1'b0, 1'b1);
    send(8'h1C, 1'b0);
    exp_byte(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);

    // extended break
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    exp_byte(8'h75, 1'b1, 1'b1);
    send(8'h75, 1'b0);

    // bad parity, then a good frame
`ifdef PS2_PARITY_CHECK_EN
    exp_err();
`else
    exp_byte(8'h1C, 1'b0, 1'b0);
`endif
    send(8'h1C, 1'b1);
    exp_byte(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);

    // 2-cycle clock glitch is filtered out
    @(posedge CLOCK); #1 PS2_CLK = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1 PS2_CLK = 1'b1;
    repeat (20) @(posedge CLOCK);
    #1 chk("glitch_state", 32'(oState), 32'd0);

    // timeout after 4 data bits
    exp_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    @(posedge CLOCK); #1 PS2_DAT = 1'b0;
    repeat (HP/2) @(posedge CLOCK);
    #1 PS2_CLK = 1'b0;
    repeat (HP) @(posedge CLOCK);
    #1 PS2_CLK = 1'b1;
    n = 0;
    while (!oErr && n < TO + 100) begin
      @(posedge CLOCK); #1;
      n++;
    end
    chk("to_latency", 32'(n), 32'(FL + 2 + TO));
    chk("to_err_state", 32'(oState), 32'd5);
    @(posedge CLOCK); #1;
    chk("to_idle", 32'(oState), 32'd0);
    PS2_DAT = 1'b1;
    repeat (20) @(posedge CLOCK);

    // prime non-zero outputs, then reset after 5 data bits
    exp_byte(8'h5A, 1'b0, 1'b0);
    send(8'h5A, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    @(posedge CLOCK); #1 RST = 1'b1;
    @(posedge CLOCK); #1;
    chk("mrst_state", 32'(oState), 32'd0);
    chk("mrst_trig", 32'(oTrig), 32'd0);
    chk("mrst_err", 32'(oErr), 32'd0);
    chk("mrst_data", 32'(oData), 32'd0);
    chk("mrst_ext", 32'(oExt), 32'd0);
    chk("mrst_brk", 32'(oBreak), 32'd0);
    RST = 1'b0;
    PS2_DAT = 1'b1;
    repeat (20) @(posedge CLOCK);
    exp_byte(8'h1C, 1'b0, 1'b0);
    send(8'h1C, 1'b0);

    repeat (50) @(posedge CLOCK);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_frame_funcmod.md
# ps2_rx_frame_funcmod

Parametrised PS/2 device-to-host frame receiver, the next generation of the keyboard receive function module. It takes raw PS2_CLK/PS2_DAT pins and synchronises and deglitches the clock line. It validates the full 11-bit frame (start, 8 data, odd parity, stop) and folds scan-code prefixes (E0 extended, F0 break) into flags. It sits between the top-level PS/2 pins and the scan-code/ASCII decoding logic, and presents one qualified byte per oTrig pulse.

## Interface
- FILTER_LEN, 4: consecutive identical synchronised samples required before a PS2_CLK level change is accepted (range 1–16).
- TIMEOUT_CYC, 100000: CLOCK cycles without a filtered PS2_CLK edge, while mid-frame, before the frame is aborted (2 ms at 50 MHz).
- CLOCK  input  1  system clock.
- RST  input  1  reset; synchronous, active-high.
- PS2_CLK  input  1  raw PS/2 clock pin, asynchronous.
- PS2_DAT  input  1  raw PS/2 data pin, asynchronous.
- oTrig  output  1  one-cycle pulse; oData/oExt/oBreak valid in this cycle.
- oData  output  8  received scan-code byte, LSB = first data bit.
- oExt  output  1  an E0 prefix preceded this byte.
- oBreak  output  1  an F0 prefix preceded this byte.
- oErr  output  1  one-cycle pulse on frame error (stop, parity, timeout).
- oState  output  3  current FSM state encoding.

## Operation
- **Input synchronisation:** PS2_CLK and PS2_DAT each pass through two flip-flops.
- **Clock filter:**
  - A saturating counter of width clog2(FILTER_LEN)+1 tracks samples that differ from the filtered level.
  - At FILTER_LEN consecutive differing samples, the filtered level flips; any matching sample clears the counter.
  - A filtered high→low transition produces a one-cycle fall pulse.
- **Sampling:** all data sampling uses the synchronised PS2_DAT on the cycle of the fall pulse.
- **FSM encoding (oState):** IDLE=0, DATA=1, PARITY=2, STOP=3, DONE=4, ERR=5.
- **FSM transitions:**
  - IDLE: on fall, if PS2_DAT=0 → DATA with bit index 0. If PS2_DAT=1, stay IDLE (spurious start bit, no error).
  - DATA: on each fall, shift the bit into shift[bit index] and increment the index. After the 8th bit → PARITY.
  - PARITY: on fall, capture the parity bit → STOP.
  - STOP: on fall, a stop bit of 1 with parity OK → DONE; otherwise → ERR.
  - DONE: one cycle, then → IDLE.
  - ERR: one cycle with oErr=1 and both prefix flags cleared, then → IDLE.
- **Parity:** OK when XOR(data[7:0], parity bit) = 1 (odd parity).
- **DONE handling:**
  - byte = 0xE0: set ext_flag; no oTrig.
  - byte = 0xF0: set brk_flag; no oTrig.
  - Any other byte:
    - oTrig=1 with oData=byte, oExt=ext_flag, oBreak=brk_flag.
    - Both flags clear on the following cycle.
    - oData/oExt/oBreak hold their values until the next oTrig.
- **Timeout:**
  - The counter clears on every filtered PS2_CLK edge (either direction) and while in IDLE.
  - In DATA/PARITY/STOP, when the counter reaches TIMEOUT_CYC-1 → ERR.
- **Reset:** RST high at any point, including mid-frame, forces all outputs to 0 on the next CLOCK edge. It also forces oState=IDLE, flags=0, filter level=1, and counters=0. The partial frame is discarded.

## Timing
- Pin falling edge to fall pulse: 2 (sync) + FILTER_LEN cycles.
- oTrig/oErr (stop/parity cases) assert exactly 1 cycle after the fall pulse that samples the stop bit.
- Timeout oErr asserts 1 cycle after the counter hits TIMEOUT_CYC-1.
- oTrig and oErr are never high in the same cycle.
- Back-to-back frames: IDLE is re-entered 2 cycles after the stop-bit sample, far below the minimum PS/2 bit period, so no frame is lost.
- **Simultaneous events:**
  - If a fall pulse coincides with timeout expiry, the fall takes priority and the counter clears.
  - A fall pulse during DONE/ERR is ignored. Legal PS/2 timing never produces one.

## Configuration
- PS2_PARITY_CHECK_EN defined: a parity failure routes STOP → ERR, pulsing oErr; no oTrig and prefix flags cleared.
- Undefined: the parity bit is captured but ignored, and only stop-bit and timeout errors occur. Flagging bad-parity frames is then the consumer's problem.

## Test plan
- **Plain make code:** frame 0x1C (parity 0, stop 1) → single oTrig, oData=0x1C, oExt=0, oBreak=0, oErr never high.
- **Break code:** frames 0xF0 then 0x1C → no oTrig after F0. One oTrig after 0x1C with oBreak=1, oExt=0. A following 0x1C gives oBreak=0.
- **Extended break:** frames 0xE0, 0xF0, 0x75 (parity 0) → one oTrig with oData=0x75, oExt=1, oBreak=1.
- **Parity error:** 0x1C sent with parity bit 1, PS2_PARITY_CHECK_EN defined → oErr pulse, no oTrig. The next good 0x1C is received normally. With the macro undefined → oTrig with oData=0x1C.
- **Timeout/glitch:**
  - PS2_CLK held high after 4 data bits → oErr exactly TIMEOUT_CYC cycles after the last filtered edge, then oState=0.
  - A 2-cycle low glitch on PS2_CLK with FILTER_LEN=4 → no state change.
- **Reset mid-frame:** RST high for 1 cycle after 5 data bits → all outputs 0 and oState=0 next cycle. A subsequent full 0x1C frame decodes correctly.
